// File: rtl/regfile_32x32_onehot_if.sv
// Bus interface for the 32x32 register file: write port, two read ports, status.
// The master drives writes and read addresses; the slave is the register file.
interface regfile_32x32_onehot_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  logic             wr_en;
  logic [DEPTH-1:0] we_sel;
  logic [WIDTH-1:0] wr_data;
  logic [4:0]       rd_addr_a;
  logic [4:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             sel_err;
  logic [15:0]      wr_count;

  modport master (
    output wr_en, we_sel, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, sel_err, wr_count
  );

  modport slave (
    input  wr_en, we_sel, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, sel_err, wr_count
  );
endinterface

// File: rtl/regfile_32x32_onehot.sv
// 32x32 register file written through a one-hot select, with two combinational
// read ports, same-cycle write bypass, select validity checking and a write counter.
module regfile_32x32_onehot #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_32x32_onehot_if.slave  rf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_sel_err;
  logic [15:0]      r_wr_count;

  logic             w_sel_valid;
  logic             w_commit;
  logic             w_reject;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign w_sel_valid = (rf.we_sel != '0) && ((rf.we_sel & (rf.we_sel - 1'b1)) == '0);
  assign w_commit    = rf.wr_en &  w_sel_valid;
  assign w_reject    = rf.wr_en & ~w_sel_valid;

  // NOTE: the array is reset because every register must read 0 after reset;
  // this rules out a RAM macro and keeps the file in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_sel_err  <= 1'b0;
      r_wr_count <= '0;
    end else begin
      if (w_commit) begin
        // Entry 0 is never loaded, which keeps it hardwired to zero.
        for (int i = 1; i < DEPTH; i++) begin
          if (rf.we_sel[i]) r_mem[i] <= rf.wr_data;
        end
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_reject) r_sel_err <= 1'b1;
    end
  end

  // NOTE: every signal in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (rst_n) begin
      if (rf.rd_addr_a != 5'd0) begin
        w_rd_a = (w_commit && rf.we_sel[rf.rd_addr_a]) ? rf.wr_data : r_mem[rf.rd_addr_a];
      end
      if (rf.rd_addr_b != 5'd0) begin
        w_rd_b = (w_commit && rf.we_sel[rf.rd_addr_b]) ? rf.wr_data : r_mem[rf.rd_addr_b];
      end
    end
  end

  assign rf.rd_data_a = w_rd_a;
  assign rf.rd_data_b = w_rd_b;
  assign rf.sel_err   = r_sel_err;
  assign rf.wr_count  = r_wr_count;

endmodule
